alu_pin_driver: RTL and testbench

//  On-chip initiator for the TinyTapeout pin interface of tt_um_alu_dgarciag44 (ui_in/uio_in in, uo_out/uio_out/uio_oe out).

---
 rtl/alu_pin_driver.sv | 169 ++++++++++++++++
 tb/tb_alu_pin_driver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pin_driver.sv
// alu_pin_driver: on-chip initiator for the TinyTapeout pin interface of an ALU design.
//
// Flow: accept one operand/opcode command over valid/ready and drive it onto the DUT pins.
// Wait a fixed DUT latency, then capture uo_out and the uio_out bits enabled by uio_oe.
// The captured values are returned over valid/ready. The block also sequences the DUT's
// rst_n/ena after its own reset.
//
// Optional feature macro: ALU_DRV_CHECK_EN
//   Adds rsp_err_o (captured uo_out != cmd_exp_i) and a saturating err_cnt_o.
//
// Ports
//   clk, rst_n        clock (also the DUT clock) and asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o, cmd_ui_i, cmd_uio_i, cmd_exp_i   command channel
//   rsp_valid_o/rsp_ready_i, rsp_uo_o, rsp_uio_o              response channel
//   dut_ui_in_o, dut_uio_in_o                                 pins driven into the DUT
//   dut_uo_out_i, dut_uio_out_i, dut_uio_oe_i                 pins read back from the DUT
//   dut_ena_o, dut_rst_n_o                                    DUT enable and reset
//   txn_cnt_o         completed transactions, wraps
//   rsp_err_o, err_cnt_o  (ALU_DRV_CHECK_EN only)
module alu_pin_driver #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       cmd_ui_i,
  input  logic [7:0]       cmd_uio_i,
  input  logic [7:0]       cmd_exp_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [7:0]       rsp_uo_o,
  output logic [7:0]       rsp_uio_o,
  output logic [7:0]       dut_ui_in_o,
  output logic [7:0]       dut_uio_in_o,
  input  logic [7:0]       dut_uo_out_i,
  input  logic [7:0]       dut_uio_out_i,
  input  logic [7:0]       dut_uio_oe_i,
  output logic             dut_ena_o,
  output logic             dut_rst_n_o,
`ifdef ALU_DRV_CHECK_EN
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] err_cnt_o,
`endif
  output logic [CNT_W-1:0] txn_cnt_o
);

  localparam int unsigned LatW = $clog2(LATENCY + 1);
  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {StRst, StIdle, StWait, StCapture, StResp} state_e;

  state_e           state_q;
  logic [LatW-1:0]  lat_cnt_q;
  logic [RstW-1:0]  rst_cnt_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_uo_q;
  logic [7:0]       rsp_uio_q;
  logic [7:0]       ui_q;
  logic [7:0]       uio_q;
  logic             ena_q;
  logic             dut_rst_n_q;
  logic [CNT_W-1:0] txn_cnt_q;
`ifdef ALU_DRV_CHECK_EN
  logic [7:0]       exp_q;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;
`else
  logic             unused_exp;
  assign unused_exp = ^cmd_exp_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRst;
      lat_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_uo_q    <= '0;
      rsp_uio_q   <= '0;
      ui_q        <= '0;
      uio_q       <= '0;
      ena_q       <= 1'b0;
      dut_rst_n_q <= 1'b0;
      txn_cnt_q   <= '0;
`ifdef ALU_DRV_CHECK_EN
      exp_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        StRst: begin
          ena_q <= 1'b1;
          // DUT reset is released first; cmd_ready follows one cycle later.
          if (dut_rst_n_q) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
          end else if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
            dut_rst_n_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (cmd_valid_i && cmd_ready_q) begin
            ui_q        <= cmd_ui_i;
            uio_q       <= cmd_uio_i;
`ifdef ALU_DRV_CHECK_EN
            exp_q       <= cmd_exp_i;
`endif
            cmd_ready_q <= 1'b0;
            lat_cnt_q   <= LatW'(LATENCY);
            state_q     <= StWait;
          end
        end
        StWait: begin
          // Counter reaches zero after LATENCY cycles in this state.
          lat_cnt_q <= lat_cnt_q - 1'b1;
          if (lat_cnt_q == LatW'(1)) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          rsp_uo_q    <= dut_uo_out_i;
          rsp_uio_q   <= dut_uio_out_i & dut_uio_oe_i;
`ifdef ALU_DRV_CHECK_EN
          err_q       <= (dut_uo_out_i != exp_q);
`endif
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            txn_cnt_q   <= txn_cnt_q + 1'b1;
`ifdef ALU_DRV_CHECK_EN
            if (err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
`endif
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StRst;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_uo_o     = rsp_uo_q;
  assign rsp_uio_o    = rsp_uio_q;
  assign dut_ui_in_o  = ui_q;
  assign dut_uio_in_o = uio_q;
  assign dut_ena_o    = ena_q;
  assign dut_rst_n_o  = dut_rst_n_q;
  assign txn_cnt_o    = txn_cnt_q;
`ifdef ALU_DRV_CHECK_EN
  assign rsp_err_o    = err_q;
  assign err_cnt_o    = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_pin_driver.sv
// Bench for alu_pin_driver with a small registered adder standing in for the ALU DUT
// (uo_out = ui_in + uio_in, one cycle latency, reset by dut_rst_n).
module tb_alu_pin_driver;

  localparam int unsigned Lat  = 1;
  localparam int unsigned RstC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_ui, cmd_uio, cmd_exp;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_uo, rsp_uio;
  logic [7:0] dut_ui_in, dut_uio_in, dut_uo_out, dut_uio_out, dut_uio_oe;
  logic       dut_ena, dut_rst_n;
  logic [7:0] txn_cnt;
`ifdef ALU_DRV_CHECK_EN
  logic       rsp_err;
  logic [7:0] err_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_pin_driver #(.LATENCY(Lat), .RST_CYCLES(RstC), .CNT_W(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_ui_i     (cmd_ui),
    .cmd_uio_i    (cmd_uio),
    .cmd_exp_i    (cmd_exp),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_uo_o     (rsp_uo),
    .rsp_uio_o    (rsp_uio),
    .dut_ui_in_o  (dut_ui_in),
    .dut_uio_in_o (dut_uio_in),
    .dut_uo_out_i (dut_uo_out),
    .dut_uio_out_i(dut_uio_out),
    .dut_uio_oe_i (dut_uio_oe),
    .dut_ena_o    (dut_ena),
    .dut_rst_n_o  (dut_rst_n),
`ifdef ALU_DRV_CHECK_EN
    .rsp_err_o    (rsp_err),
    .err_cnt_o    (err_cnt),
`endif
    .txn_cnt_o    (txn_cnt)
  );

  // Stand-in ALU: registered ADD.
  always @(posedge clk or negedge dut_rst_n) begin
    if (!dut_rst_n) dut_uo_out <= 8'h00;
    else if (dut_ena) dut_uo_out <= 8'(dut_ui_in + dut_uio_in);
  end

  typedef struct packed {
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] uio_drv;
    logic [7:0] oe_drv;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Release own reset and measure the DUT reset window and cmd_ready rise.
  task automatic release_and_check(input string tag);
    int zeros;
    int seen_rsp;
    zeros = 0;
    seen_rsp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    if (!dut_rst_n) zeros++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
      if (dut_rst_n) break;
      zeros++;
    end
    chk({tag, " dut_rst_n low cycles"}, zeros, RstC);
    chk({tag, " dut_ena in RST"}, dut_ena, 1);
    chk({tag, " cmd_ready at dut_rst_n rise"}, cmd_ready, 0);
    @(negedge clk);
    chk({tag, " cmd_ready next cycle"}, cmd_ready, 1);
    chk({tag, " no rsp_valid during RST"}, seen_rsp, 0);
  endtask

  // Issue one command; returns at the negedge where rsp_valid is first seen and the
  // number of cycles counted from the accept cycle.
  task automatic run_txn(input logic [7:0] ui, input logic [7:0] uio, input logic [7:0] exp,
                         output int lat);
    int w;
    @(negedge clk);
    cmd_ui = ui;
    cmd_uio = uio;
    cmd_exp = exp;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("cmd_ready timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [7:0] cnt;
    vecs[0] = '{ui: 8'h05, uio: 8'h03, uio_drv: 8'hFF, oe_drv: 8'h0F, exp_uo: 8'h08,
                exp_uio: 8'h0F};
    vecs[1] = '{ui: 8'hFF, uio: 8'h01, uio_drv: 8'hAA, oe_drv: 8'hF0, exp_uo: 8'h00,
                exp_uio: 8'hA0};
    vecs[2] = '{ui: 8'h80, uio: 8'h81, uio_drv: 8'h00, oe_drv: 8'hFF, exp_uo: 8'h01,
                exp_uio: 8'h00};
    vecs[3] = '{ui: 8'h12, uio: 8'h34, uio_drv: 8'h5A, oe_drv: 8'hFF, exp_uo: 8'h46,
                exp_uio: 8'h5A};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_ui = 8'h00;
    cmd_uio = 8'h00;
    cmd_exp = 8'h00;
    rsp_ready = 1'b1;
    dut_uio_out = 8'h00;
    dut_uio_oe = 8'h00;
    repeat (3) @(negedge clk);

    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_uo/uio", {rsp_uo, rsp_uio}, 0);
    chk("reset dut pins", {dut_ui_in, dut_uio_in}, 0);
    chk("reset dut_ena/rst_n", {dut_ena, dut_rst_n}, 0);
    chk("reset txn_cnt", txn_cnt, 0);
`ifdef ALU_DRV_CHECK_EN
    chk("reset rsp_err/err_cnt", {rsp_err, err_cnt}, 0);
`endif
    release_and_check("first");

    for (int i = 0; i < 4; i++) begin
      dut_uio_out = vecs[i].uio_drv;
      dut_uio_oe = vecs[i].oe_drv;
      run_txn(vecs[i].ui, vecs[i].uio, vecs[i].exp_uo, lat);
      chk($sformatf("vec%0d latency", i), lat, Lat + 2);
      chk($sformatf("vec%0d rsp_uo", i), rsp_uo, vecs[i].exp_uo);
      chk($sformatf("vec%0d rsp_uio", i), rsp_uio, vecs[i].exp_uio);
`ifdef ALU_DRV_CHECK_EN
      chk($sformatf("vec%0d rsp_err", i), rsp_err, 0);
`endif
      @(negedge clk);
      chk($sformatf("vec%0d rsp_valid drop", i), rsp_valid, 0);
      chk($sformatf("vec%0d txn_cnt", i), txn_cnt, i + 1);
      chk($sformatf("vec%0d cmd_ready back", i), cmd_ready, 1);
      chk($sformatf("vec%0d pins held", i), {dut_ui_in, dut_uio_in},
          {vecs[i].ui, vecs[i].uio});
    end

    // Back-pressure: response must hold and no new command may be taken.
    rsp_ready = 1'b0;
    dut_uio_out = 8'h3C;
    dut_uio_oe = 8'hFF;
    run_txn(8'h21, 8'h11, 8'h32, lat);
    chk("hold latency", lat, Lat + 2);
    cmd_ui = 8'h40;
    cmd_uio = 8'h01;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d rsp", k), {rsp_valid, rsp_uo, rsp_uio}, {1'b1, 8'h32, 8'h3C});
      chk($sformatf("hold%0d cmd_ready", k), cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold txn_cnt", txn_cnt, 5);
    chk("hold pins unchanged", {dut_ui_in, dut_uio_in}, 16'h2111);
    @(negedge clk);
    chk("hold no extra accept", {cmd_ready, rsp_valid}, 2'b10);

`ifdef ALU_DRV_CHECK_EN
    run_txn(8'h05, 8'h03, 8'h09, lat);
    chk("err rsp_uo", rsp_uo, 8'h08);
    chk("err rsp_err", rsp_err, 1);
    @(negedge clk);
    chk("err err_cnt 1", err_cnt, 1);
    for (int k = 1; k < 256; k++) begin
      run_txn(8'h05, 8'h03, 8'h09, lat);
      @(negedge clk);
    end
    chk("err err_cnt saturated", err_cnt, 8'hFF);
    cnt = txn_cnt;
    chk("err txn_cnt wrapped", cnt, 8'(5 + 256));
`endif

    // Reset during WAIT discards the transaction and re-runs the DUT reset sequence.
    run_txn_partial();
    rst_n = 1'b0;
    #1;
    chk("midreset rsp_valid", rsp_valid, 0);
    chk("midreset txn_cnt", txn_cnt, 0);
    chk("midreset dut_rst_n/ena", {dut_rst_n, dut_ena}, 0);
    chk("midreset pins", {dut_ui_in, dut_uio_in}, 0);
    repeat (2) @(negedge clk);
    release_and_check("again");

    dut_uio_out = 8'hFF;
    dut_uio_oe = 8'h0F;
    run_txn(8'h05, 8'h03, 8'h08, lat);
    chk("post-reset latency", lat, Lat + 2);
    chk("post-reset rsp", {rsp_uo, rsp_uio}, 16'h080F);
    @(negedge clk);
    chk("post-reset txn_cnt", txn_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Accept a command and stop at the first cycle of WAIT.
  task automatic run_txn_partial();
    int w;
    @(negedge clk);
    cmd_ui = 8'h66;
    cmd_uio = 8'h11;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("partial cmd_ready timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("partial in WAIT", {cmd_ready, rsp_valid, dut_ui_in}, {2'b00, 8'h66});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
